// File: rtl/fir_interp2_pkg.sv
// fir_interp2_pkg
// Shared definitions for the 2x polyphase interpolator: FSM state encoding,
// default widths and the Q14 coefficient set of the 7-tap symmetric low-pass.
package fir_interp2_pkg;

    localparam int IN_W_D  = 8;
    localparam int ACC_W_D = 24;
    localparam int SHIFT_D = 14;
    localparam int OUT_W_D = 10;

    // Prototype taps h[0..6] = C0 C1 C2 C3 C2 C1 C0 (Q14).
    // Even taps form phase 0, odd taps form phase 1.
    localparam int C0 = -1495;
    localparam int C1 = -942;
    localparam int C2 = 9687;
    localparam int C3 = 18269;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2
    } state_t;

endpackage

// File: rtl/fir_interp2_mcm.sv
// interp2_mcm
// Combinational multiple-constant multiplier. Produces the four coefficient
// magnitudes needed by the interpolator from one operand, sharing a single
// shift-add graph (9x -> 41x -> 471x) so no multipliers are inferred.
// Ports:
//   x       operand, W bits two's complement
//   p1495   1495 * x
//   p942    942 * x
//   p9687   9687 * x
//   p18269  18269 * x
module interp2_mcm #(
    parameter int W = 24
) (
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] p1495,
    output logic signed [W-1:0] p942,
    output logic signed [W-1:0] p9687,
    output logic signed [W-1:0] p18269
);

    logic signed [W-1:0] p9;
    logic signed [W-1:0] p41;
    logic signed [W-1:0] p471;

    assign p9     = (x <<< 3) + x;                    // 8 + 1
    assign p41    = (x <<< 5) + p9;                   // 32 + 9
    assign p471   = (x <<< 9) - p41;                  // 512 - 41
    assign p1495  = (x <<< 10) + p471;                // 1024 + 471
    assign p942   = p471 <<< 1;                       // 2 * 471
    assign p9687  = (x <<< 13) + p1495;               // 8192 + 1495
    assign p18269 = (x <<< 14) + (p471 <<< 2) + x;    // 16384 + 1884 + 1

endmodule

// File: rtl/fir_interp2.sv
// fir_interp2
// 2x polyphase interpolator built on the 7-tap symmetric Q14 low-pass.
// Every accepted input sample yields two output samples, phase 0 then
// phase 1. Both phase sums are computed at accept time and held in
// registers, so backpressure only stalls the FSM and never touches history.
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   in_valid    input sample valid
//   in_ready    block accepts a sample this cycle
//   in_data     signed input sample, IN_W bits
//   out_valid   out_data holds a valid output sample
//   out_ready   downstream accepts out_data this cycle
//   out_data    signed interpolated sample, OUT_W bits
import fir_interp2_pkg::*;

module fir_interp2 #(
    parameter int IN_W  = IN_W_D,
    parameter int ACC_W = ACC_W_D,
    parameter int SHIFT = SHIFT_D,
    parameter int OUT_W = OUT_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int NTAP = 4;

    state_t                 state;
    logic   [ACC_W-1:0]     dl0, dl1, dl2;
    logic   [ACC_W-1:0]     y0_r, y1_r;
    logic   [ACC_W-1:0]     x_ext;
    logic   [ACC_W-1:0]     y0, y1;
    logic                   accept;

    // tap[0] = x[n], tap[1..3] = x[n-1..n-3]
    logic [NTAP-1:0][ACC_W-1:0] tap;
    logic [NTAP-1:0][ACC_W-1:0] m1495, m942, m9687, m18269;

    assign x_ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign tap   = {dl2, dl1, dl0, x_ext};

    for (genvar i = 0; i < NTAP; i++) begin : g_mcm
        interp2_mcm #(.W(ACC_W)) u_mcm (
            .x      (tap[i]),
            .p1495  (m1495[i]),
            .p942   (m942[i]),
            .p9687  (m9687[i]),
            .p18269 (m18269[i])
        );
    end

    // Phase 0 uses even taps (C0 C2 C2 C0), phase 1 odd taps (C1 C3 C1).
    assign y0 = m9687[1] + m9687[2] - m1495[0] - m1495[3];
    assign y1 = m18269[1] - m942[0] - m942[2];

    // PH1 may hand over directly to a new sample: the last phase-1 output
    // leaves on the same edge the next sample enters, giving no bubble.
    // This makes in_ready combinationally dependent on out_ready.
    assign in_ready  = (state == IDLE) || ((state == PH1) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state != IDLE);

    always_comb begin
        out_data = '0;
        case (state)
            PH0:     out_data = y0_r[SHIFT+OUT_W-1:SHIFT];
            PH1:     out_data = y1_r[SHIFT+OUT_W-1:SHIFT];
            default: out_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dl0   <= '0;
            dl1   <= '0;
            dl2   <= '0;
            y0_r  <= '0;
            y1_r  <= '0;
        end else if (accept) begin
            y0_r  <= y0;
            y1_r  <= y1;
            dl0   <= x_ext;
            dl1   <= dl0;
            dl2   <= dl1;
            state <= PH0;
        end else begin
            case (state)
                PH0:     if (out_ready) state <= PH1;
                PH1:     if (out_ready) state <= IDLE;
                IDLE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Products that no phase sum consumes, plus register bits outside the
    // output slice.
    logic unused_bits;
    assign unused_bits = ^{m1495[2:1], m942[3], m942[1], m9687[3], m9687[0],
                           m18269[3:2], m18269[0], y0_r, y1_r};

endmodule

// File: tb/tb_fir_interp2.sv
// tb_fir_interp2
// Scoreboard bench for fir_interp2. Accepted samples feed a reference model
// that evaluates the polyphase sums directly from the 7 prototype taps; a
// monitor pops expected values whenever an output handshake occurs.
import fir_interp2_pkg::*;

module tb_fir_interp2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] out_data;

    fir_interp2 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int hist[$];    // accepted samples, newest first
    int exp_q[$];   // expected outputs in order
    int got_q[$];   // log of accepted output values

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int xn(input int i);
        return (i < hist.size()) ? hist[i] : 0;
    endfunction

    // Output phase p of the newest sample: sum of h[k]*x[n-k/2] over k with
    // k%2 == p, floored by 2^14 and wrapped to the 10-bit output.
    function automatic int ref_phase(input int p);
        int h[7] = '{C0, C1, C2, C3, C2, C1, C0};
        int s = 0;
        logic signed [9:0] t;
        for (int k = p; k < 7; k += 2) s += h[k] * xn(k / 2);
        s = s >>> 14;
        t = s[9:0];
        return int'(t);
    endfunction

    // Model + monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                hist.push_front(int'($signed(in_data)));
                if (hist.size() > 4) void'(hist.pop_back());
                exp_q.push_back(ref_phase(0));
                exp_q.push_back(ref_phase(1));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got %0d expected none", int'($signed(out_data)));
                end else begin
                    chk("sb_data", int'($signed(out_data)), exp_q.pop_front());
                end
                got_q.push_back(int'($signed(out_data)));
            end
        end
    end

    // Called right after a rising edge; returns right after the edge that
    // accepted the sample.
    task automatic send(input int v);
        int t = 0;
        in_valid = 1'b1;
        in_data  = v[7:0];
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                chk("send_timeout", t, 0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_seq(input string nm, input int exp[]);
        chk({nm, "_len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            chk(nm, got_q[i], exp[i]);
    endtask

    int imp[] = '{-6, -4, 37, 71, 37, -4, -6, 0, 0, 0};

    initial begin
        int sent;
        bit took;

        // Reset state
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_data", int'(out_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Impulse
        got_q.delete();
        send(64);
        repeat (4) send(0);
        drain();
        chk_seq("impulse", imp);

        // Positive DC: steady state from 4th sample
        got_q.delete();
        repeat (6) send(100);
        drain();
        for (int i = 6; i < 12 && i < got_q.size(); i++) chk("dc_pos", got_q[i], 100);

        // Negative DC: floor gives -128 / -129
        got_q.delete();
        repeat (6) send(-128);
        drain();
        for (int i = 6; i < 12 && i < got_q.size(); i += 2) begin
            chk("dc_neg_ph0", got_q[i], -128);
            if (i + 1 < got_q.size()) chk("dc_neg_ph1", got_q[i+1], -129);
        end
        repeat (3) send(0);
        drain();

        // Backpressure in PH0 and PH1
        got_q.delete();
        out_ready = 1'b0;
        send(64);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ph0_valid", int'(out_valid), 1);
            chk("bp_ph0_data", int'($signed(out_data)), -6);
            chk("bp_ph0_in_ready", int'(in_ready), 0);
            in_data = 8'($urandom);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ph1_data", int'($signed(out_data)), -4);
            chk("bp_ph1_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) send(0);
        drain();
        chk_seq("bp_seq", imp);

        // Back-to-back: in_valid held high, data changing every cycle
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i >= 1) chk("b2b_out_valid", int'(out_valid), 1);
            chk("b2b_in_ready", int'(in_ready), (i % 2 == 0) ? 1 : 0);
            @(posedge clk); #1;
            in_data = 8'($urandom);
        end
        in_valid = 1'b0;
        drain();

        // Randomized traffic with random backpressure
        sent = 0;
        took = 1'b0;
        for (int c = 0; c < 2000 && sent < 60; c++) begin
            if (took) in_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset while in PH1 with history loaded
        send(37);
        send(-90);
        @(negedge clk);          // phase 0 handshake
        @(posedge clk); #3;      // now in PH1
        chk("pre_rst_ph1_valid", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_data", int'(out_data), 0);
        exp_q.delete();
        hist.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_in_ready", int'(in_ready), 1);
        got_q.delete();
        send(64);
        repeat (4) send(0);
        drain();
        chk_seq("rst_impulse", imp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
